hdmi_iic_arbiter: RTL

Parametrised I2C initialisation hub for the HDMI front end: it lets CH_NUM register-init controllers (MS7200 RX, MS7210 TX, and later parts) share one I2C master driver instead of one driver per chip. It sequences the controllers' reset releases, arbitrates their byte transactions onto the single master, and routes completion and read data back to the requester. It sits between the per-chip `*_ctrl` blocks and one `iic_*_driver` instance.

---
 rtl/hdmi_iic_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/hdmi_iic_arbiter.sv
// I2C hub for the HDMI front end: sequences controller resets and
// arbitrates their byte transactions onto one shared master driver.
module hdmi_iic_arbiter #(
  parameter int CH_NUM      = 2,
  parameter int ADDR_W      = 16,
  parameter int SEQ_MODE    = 1,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CH_NUM-1:0]        req_trig,
  input  logic [CH_NUM-1:0]        req_w_r,
  input  logic [8*CH_NUM-1:0]      req_dev_id,
  input  logic [ADDR_W*CH_NUM-1:0] req_addr,
  input  logic [8*CH_NUM-1:0]      req_data,
  input  logic [CH_NUM-1:0]        ch_init_over,
  output logic [CH_NUM-1:0]        ch_rstn,
  output logic [CH_NUM-1:0]        ch_busy,
  output logic [CH_NUM-1:0]        ch_byte_over,
  output logic [8*CH_NUM-1:0]      ch_data_out,
  output logic                     all_init_over,
  output logic [CH_NUM-1:0]        timeout_err,
  output logic                     m_trig,
  output logic                     m_w_r,
  output logic [7:0]               m_dev_id,
  output logic [ADDR_W-1:0]        m_addr,
  output logic [7:0]               m_data_in,
  input  logic                     m_busy,
  input  logic                     m_byte_over,
  input  logic [7:0]               m_data_out
);

  localparam int PW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int CW = ($clog2(TIMEOUT_CYC + 1) > 0) ?
                      $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t              state;
  logic [PW-1:0]       ptr;
  logic [PW-1:0]       gnt;
  logic [CW-1:0]       cnt;
  logic [CH_NUM-1:0]   pending;
  logic [CH_NUM-1:0]   pend_clr;
  logic [CH_NUM-1:0]   rstn_nxt;
  logic                sel_found;
  logic [PW-1:0]       sel_idx;
  logic [PW-1:0]       cand;
  logic                tmo_hit;

  assign ch_busy = pending;
  assign tmo_hit = (cnt == CW'(TIMEOUT_CYC));

  // Round-robin: first pending channel strictly after the last grant.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= CH_NUM; i++) begin
      cand = PW'((int'(ptr) + i) % CH_NUM);
      if (!sel_found && pending[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    pend_clr = '0;
    unique case (1'b1)
      (state == WAIT_BUSY): begin
        if (!m_busy && tmo_hit)
          pend_clr[gnt] = 1'b1;
      end
      (state == WAIT_DONE): begin
        if (!m_busy)
          pend_clr[gnt] = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    rstn_nxt = '1;
    if (SEQ_MODE != 0) begin
      for (int k = 1; k < CH_NUM; k++)
        rstn_nxt[k] = ch_init_over[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_rstn       <= '0;
      all_init_over <= 1'b0;
    end else begin
      ch_rstn       <= rstn_nxt;
      all_init_over <= &ch_init_over;
    end
  end

  // Set wins over clear so a retrigger at completion is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pending <= '0;
    else
      pending <= (pending & ~pend_clr) | (req_trig & ch_rstn);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= PW'(CH_NUM - 1);
      gnt          <= '0;
      cnt          <= '0;
      m_trig       <= 1'b0;
      m_w_r        <= 1'b0;
      m_dev_id     <= '0;
      m_addr       <= '0;
      m_data_in    <= '0;
      ch_byte_over <= '0;
      ch_data_out  <= '0;
      timeout_err  <= '0;
    end else begin
      m_trig       <= 1'b0;
      ch_byte_over <= '0;
      unique case (state)
        IDLE: begin
          if (sel_found) begin
            gnt       <= sel_idx;
            ptr       <= sel_idx;
            cnt       <= '0;
            m_trig    <= 1'b1;
            m_w_r     <= req_w_r[sel_idx];
            m_dev_id  <= req_dev_id[8*int'(sel_idx) +: 8];
            m_addr    <= req_addr[ADDR_W*int'(sel_idx) +: ADDR_W];
            m_data_in <= req_data[8*int'(sel_idx) +: 8];
            state     <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (m_busy) begin
            state <= WAIT_DONE;
          end else if (tmo_hit) begin
            timeout_err[gnt] <= 1'b1;
            state            <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (m_byte_over) begin
            ch_byte_over[gnt]              <= 1'b1;
            ch_data_out[8*int'(gnt) +: 8] <= m_data_out;
          end
          if (!m_busy)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
